xintf_mc_slave: RTL and testbench

Parametrised multi-channel slave for the DSP XINTF external bus, running on clk50M. It synchronises the asynchronous XINTF strobes, decodes the XINTF address onto NUM_CH internal channels, and drives read data from the selected channel's source (typically a FIFO head) onto xdata. It captures write data and presents it as a single-cycle write beat with its channel address. It adds timeout, abort and bus-error detection.

---
 rtl/xintf_mc_slave.sv | 183 ++++++++++++++++++
 tb/tb_xintf_mc_slave.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xintf_mc_slave.sv
// XINTF multi-channel slave: synchronised strobes, channel decode, read drive, write capture.
// Optional macro XINTF_RD_LATCH_EN holds the read word from READ entry instead of muxing live.
`timescale 1ns/1ps
module xintf_mc_slave #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 4,
    parameter int NUM_CH         = 4,
    parameter int RD_HOLD_CYC    = 11,
    parameter int WR_TIMEOUT_CYC = 31,
    parameter int CNT_W          = 5
) (
    input  logic                     clk50M,
    input  logic                     rst_n,
    input  logic                     xcs_n,
    input  logic                     xrd_n,
    input  logic                     xwe_n,
    input  logic [ADDR_W-1:0]        xaddr,
    inout  wire  [DATA_W-1:0]        xdata,
    input  logic [NUM_CH*DATA_W-1:0] ch_rd_data,
    output logic [NUM_CH-1:0]        ch_rd_pop,
    output logic                     rd_end,
    output logic [DATA_W-1:0]        wr_data,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic                     wr_valid,
    output logic                     bus_err
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_TIMEOUT_CYC - 1);

    // Bit 0 = xcs_n, bit 1 = xrd_n, bit 2 = xwe_n.
    logic [2:0]        sync1_q, sync2_q, hist_q;
    logic              cs_s, rd_fall, we_fall, we_rise;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] shadow_q, shadow_d, wr_data_q, wr_data_d, rd_word;
    logic [NUM_CH-1:0] pop_q, pop_d, xaddr_hit;
    logic              rd_end_q, rd_end_d, wr_valid_q, wr_valid_d, berr_q, berr_d;

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
            hist_q  <= 3'b111;
        end else begin
            sync1_q <= {xwe_n, xrd_n, xcs_n};
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign cs_s    = sync2_q[0];
    assign rd_fall = hist_q[1] & ~sync2_q[1];
    assign we_fall = hist_q[2] & ~sync2_q[2];
    assign we_rise = ~hist_q[2] & sync2_q[2];

    always_comb begin
        xaddr_hit = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (xaddr == ADDR_W'(k)) xaddr_hit[k] = 1'b1;
    end

`ifdef XINTF_RD_LATCH_EN
    logic [DATA_W-1:0] hold_q, sel_word;

    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (xaddr_hit[k]) sel_word = ch_rd_data[k*DATA_W +: DATA_W];
    end

    // Captured on the pop edge so a FIFO head advancing on pop cannot disturb the read.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) hold_q <= '0;
        else if (state_q == IDLE && state_d == READ) hold_q <= sel_word;
    end

    assign rd_word = hold_q;
`else
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (addr_q == ADDR_W'(k)) rd_word = ch_rd_data[k*DATA_W +: DATA_W];
    end
`endif

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        addr_d     = addr_q;
        shadow_d   = shadow_q;
        wr_data_d  = wr_data_q;
        wr_addr_d  = wr_addr_q;
        pop_d      = '0;
        rd_end_d   = 1'b0;
        wr_valid_d = 1'b0;
        berr_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!cs_s && rd_fall && we_fall) begin
                    berr_d = 1'b1;
                end else if (!cs_s && rd_fall) begin
                    addr_d  = xaddr;
                    state_d = READ;
                    timer_d = '0;
                    pop_d   = xaddr_hit;
                    berr_d  = ~|xaddr_hit;
                end else if (!cs_s && we_fall) begin
                    addr_d  = xaddr;
                    state_d = WRITE;
                    timer_d = '0;
                end
            end
            READ: begin
                if (cs_s || timer_q == RD_LAST) begin
                    state_d  = IDLE;
                    timer_d  = '0;
                    rd_end_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WRITE: begin
                shadow_d = xdata;
                // cs release outranks timeout, which outranks the write strobe edge.
                if (cs_s) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == WR_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                    berr_d  = 1'b1;
                end else if (we_rise) begin
                    state_d    = IDLE;
                    timer_d    = '0;
                    wr_data_d  = shadow_q;
                    wr_addr_d  = addr_q;
                    wr_valid_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            addr_q     <= '0;
            shadow_q   <= '0;
            wr_data_q  <= '0;
            wr_addr_q  <= '0;
            pop_q      <= '0;
            rd_end_q   <= 1'b0;
            wr_valid_q <= 1'b0;
            berr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            addr_q     <= addr_d;
            shadow_q   <= shadow_d;
            wr_data_q  <= wr_data_d;
            wr_addr_q  <= wr_addr_d;
            pop_q      <= pop_d;
            rd_end_q   <= rd_end_d;
            wr_valid_q <= wr_valid_d;
            berr_q     <= berr_d;
        end
    end

    assign xdata     = (state_q == READ) ? rd_word : {DATA_W{1'bz}};
    assign ch_rd_pop = pop_q;
    assign rd_end    = rd_end_q;
    // wr_valid has no back-pressure: wr_data/wr_addr are valid only in the cycle wr_valid is high.
    assign wr_data   = wr_data_q;
    assign wr_addr   = wr_addr_q;
    assign wr_valid  = wr_valid_q;
    assign bus_err   = berr_q;
endmodule

// File: tb/tb_xintf_mc_slave.sv
// Bench for xintf_mc_slave: random XINTF reads/writes checked against per-transaction expectations.
`timescale 1ns/1ps
module tb_xintf_mc_slave;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 4;
  localparam int NUM_CH  = 4;
  localparam int RD_HOLD = 11;
  localparam int WR_TO   = 31;
  // The bus has pull-ups, so an undriven xdata reads as all ones; test words avoid that value.
  localparam logic [DATA_W-1:0] IDLE_BUS = 16'hFFFF;

  logic                     clk50M = 1'b0;
  logic                     rst_n;
  logic                     xcs_n, xrd_n, xwe_n;
  logic [ADDR_W-1:0]        xaddr;
  wire  [DATA_W-1:0]        xdata;
  logic [NUM_CH*DATA_W-1:0] ch_rd_data;
  logic [NUM_CH-1:0]        ch_rd_pop;
  logic                     rd_end, wr_valid, bus_err;
  logic [DATA_W-1:0]        wr_data;
  logic [ADDR_W-1:0]        wr_addr;

  logic [DATA_W-1:0] tb_val;
  logic              tb_en;
  logic [DATA_W-1:0] ch_mem [NUM_CH];

  assign xdata = tb_en ? tb_val : {DATA_W{1'bz}};
  for (genvar i = 0; i < DATA_W; i++) begin : g_pu
    pullup (xdata[i]);
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) ch_rd_data[k*DATA_W +: DATA_W] = ch_mem[k];
  end

  xintf_mc_slave dut (
    .clk50M(clk50M), .rst_n(rst_n), .xcs_n(xcs_n), .xrd_n(xrd_n), .xwe_n(xwe_n),
    .xaddr(xaddr), .xdata(xdata), .ch_rd_data(ch_rd_data), .ch_rd_pop(ch_rd_pop),
    .rd_end(rd_end), .wr_data(wr_data), .wr_addr(wr_addr), .wr_valid(wr_valid),
    .bus_err(bus_err)
  );

  // clock / reset
  always #10 clk50M = ~clk50M;

  // monitor: cumulative event counters sampled on the falling edge
  int                cyc = 0, pop_cnt = 0, rd_end_cnt = 0, rd_end_drv = 0;
  int                berr_cnt = 0, wv_cnt = 0, wv_cyc = 0;
  logic [NUM_CH-1:0] last_pop = '0;
  logic [DATA_W-1:0] last_wd = '0;
  logic [ADDR_W-1:0] last_wa = '0;
  logic [DATA_W-1:0] drv_q [$];

  always @(negedge clk50M) begin
    cyc <= cyc + 1;
    if (ch_rd_pop != '0) begin
      pop_cnt  <= pop_cnt + 1;
      last_pop <= ch_rd_pop;
    end
    if (rd_end) begin
      rd_end_cnt <= rd_end_cnt + 1;
      if (xdata != IDLE_BUS) rd_end_drv <= rd_end_drv + 1;
    end
    if (bus_err) berr_cnt <= berr_cnt + 1;
    if (wr_valid) begin
      wv_cnt  <= wv_cnt + 1;
      wv_cyc  <= cyc + 1;
      last_wd <= wr_data;
      last_wa <= wr_addr;
    end
    if (!tb_en && xdata != IDLE_BUS) drv_q.push_back(xdata);
  end

  // scoreboard bookkeeping
  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk50M);
      #2;
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    return DATA_W'($urandom_range(0, 32'hFFFE));
  endfunction

  task automatic do_read(input logic [ADDR_W-1:0] addr, input bit cs_cut);
    int p0 = pop_cnt, e0 = rd_end_cnt, b0 = berr_cnt, d0 = drv_q.size(), r0 = rd_end_drv;
    int waited = 0, n, nbad = 0;
    bit mapped = (int'(addr) < NUM_CH);
    logic [DATA_W-1:0] expw = mapped ? ch_mem[addr[1:0]] : '0;
    xaddr = addr;
    xcs_n = 1'b0;
    tick(1);
    xrd_n = 1'b0;
    if (cs_cut) begin
      while (drv_q.size() == d0 && waited < 20) begin
        tick(1);
        waited++;
      end
      check("rd_start", 32'(drv_q.size() > d0), 1);
      tick(3);
      xcs_n = 1'b1;
      tick(8);
    end else begin
      for (int i = 0; i < 18; i++) begin
        tick(1);
`ifdef XINTF_RD_LATCH_EN
        if (waited == 0 && pop_cnt > p0) begin
          ch_mem[addr[1:0]] = rand_word();
          waited = 1;
        end
`endif
      end
    end
    xrd_n = 1'b1;
    xcs_n = 1'b1;
    tick(4);
    n = drv_q.size() - d0;
    check("rd_pop_cnt", pop_cnt - p0, mapped ? 1 : 0);
    if (mapped) check("rd_pop_val", last_pop, 32'(1) << addr);
    check("rd_berr", berr_cnt - b0, mapped ? 0 : 1);
    check("rd_end_cnt", rd_end_cnt - e0, 1);
    check("rd_end_hiz", rd_end_drv - r0, 0);
    if (cs_cut) check("rd_cut_len", 32'(n >= 3 && n < RD_HOLD), 1);
    else        check("rd_len", n, RD_HOLD);
    for (int i = d0; i < drv_q.size(); i++)
      if (drv_q[i] != expw) nbad++;
    check("rd_word_bad", nbad, 0);
    if (n > 0) check("rd_word", drv_q[d0], expw);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                          input int low, input bit cs_cut);
    int w0 = wv_cnt, b0 = berr_cnt, t0 = 0;
    bit timeout = (low >= WR_TO);
    bit exp_wv = !timeout && !cs_cut;
    xaddr  = addr;
    tb_val = data;
    tb_en  = 1'b1;
    xcs_n  = 1'b0;
    tick(1);
    xwe_n = 1'b0;
    if (cs_cut) begin
      tick(6);
      xcs_n = 1'b1;
      tick(4);
      xwe_n = 1'b1;
      tick(6);
    end else begin
      tick(low);
      xwe_n = 1'b1;
      t0 = cyc;
      tick(8);
    end
    tb_en = 1'b0;
    xcs_n = 1'b1;
    tick(4);
    check("wr_valid_cnt", wv_cnt - w0, exp_wv ? 1 : 0);
    check("wr_berr", berr_cnt - b0, timeout ? 1 : 0);
    if (exp_wv) begin
      check("wr_data", last_wd, data);
      check("wr_addr", last_wa, addr);
      check("wr_latency", wv_cyc - t0, 4);
    end
  endtask

  initial begin
    int waited;
    int d0;
    int b0;
    rst_n = 1'b0;
    xcs_n = 1'b1;
    xrd_n = 1'b1;
    xwe_n = 1'b1;
    xaddr = '0;
    tb_en = 1'b0;
    tb_val = '0;
    for (int k = 0; k < NUM_CH; k++) ch_mem[k] = rand_word();
    tick(3);
    check("rst_xdata", xdata, IDLE_BUS);
    check("rst_pop", ch_rd_pop, 0);
    check("rst_rd_end", rd_end, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_bus_err", bus_err, 0);
    rst_n = 1'b1;
    tick(3);

    ch_mem[2] = 16'hA5A5;
    do_read(4'd2, 1'b0);
    do_write(4'd1, 16'h1234, 8, 1'b0);
    do_write(4'd3, 16'h5A5A, 40, 1'b0);
    do_read(4'd7, 1'b0);
    do_read(4'd1, 1'b1);
    do_write(4'd2, 16'h0F0F, 0, 1'b1);

    // rd and we fall together: error, nothing driven, no pop
    d0 = drv_q.size();
    b0 = berr_cnt;
    waited = pop_cnt;
    xaddr = 4'd0;
    xcs_n = 1'b0;
    tick(1);
    xrd_n = 1'b0;
    xwe_n = 1'b0;
    tick(8);
    xrd_n = 1'b1;
    xwe_n = 1'b1;
    xcs_n = 1'b1;
    tick(4);
    check("both_berr", berr_cnt - b0, 1);
    check("both_hiz", drv_q.size() - d0, 0);
    check("both_pop", pop_cnt - waited, 0);

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NUM_CH; k++) ch_mem[k] = rand_word();
      do_read(ADDR_W'($urandom_range(0, 7)), 1'b0);
      do_write(ADDR_W'($urandom_range(0, 15)), rand_word(), $urandom_range(3, 20), 1'b0);
    end

    // reset asserted in the middle of a read
    d0 = drv_q.size();
    xaddr = 4'd0;
    xcs_n = 1'b0;
    tick(1);
    xrd_n = 1'b0;
    waited = 0;
    while (drv_q.size() == d0 && waited < 20) begin
      tick(1);
      waited++;
    end
    check("mid_rd_start", 32'(drv_q.size() > d0), 1);
    tick(2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_xdata", xdata, IDLE_BUS);
    check("mid_rst_pop", ch_rd_pop, 0);
    check("mid_rst_rd_end", rd_end, 0);
    check("mid_rst_wr_data", wr_data, 0);
    check("mid_rst_wr_addr", wr_addr, 0);
    check("mid_rst_wr_valid", wr_valid, 0);
    check("mid_rst_bus_err", bus_err, 0);
    tick(2);
    xrd_n = 1'b1;
    xcs_n = 1'b1;
    rst_n = 1'b1;
    tick(4);
    do_read(4'd3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
